// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared opcodes, FSM state encodings and flag bit indices for
//             the sequential ALU.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  typedef logic [2:0] op_t;

  // Opcodes
  localparam op_t OP_AND = 3'b000;
  localparam op_t OP_OR  = 3'b001;
  localparam op_t OP_XOR = 3'b010;
  localparam op_t OP_ADD = 3'b011;
  localparam op_t OP_SUB = 3'b100;
  localparam op_t OP_SLT = 3'b101;
  localparam op_t OP_MUL = 3'b110;
  localparam op_t OP_NOT = 3'b111;

  // FSM state encodings
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Bit positions inside the packed flag vector
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

endpackage
`default_nettype wire

// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu_if
//  Purpose  : Operation-in / result-out handshake bundle of the sequential
//             ALU. master = operand source and result consumer,
//             slave = the ALU.
//  Revision : 1.0  initial release
// ============================================================================
interface seq_alu_if #(
  parameter int WIDTH = 4
);

  logic               in_valid;
  logic               in_ready;
  logic [2:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               flag_z;
  logic               flag_c;
  logic               flag_v;
  logic               flag_n;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_c, flag_v, flag_n
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flag_z, flag_c, flag_v, flag_n
  );

endinterface
`default_nettype wire

// File: rtl/seq_alu_mul_serial.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mul_serial
//  Purpose  : Unsigned shift-add multiplier. Loads operands on i_start, then
//             performs one step per cycle for WIDTH cycles, multiplier LSB
//             first. o_done marks the cycle of the last step; o_product is
//             the accumulator value after the current step, so it holds the
//             final product exactly while o_done is high.
//  Revision : 1.0  initial release
// ============================================================================
module alu_mul_serial #(
  parameter int WIDTH = 4
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               i_start,
  input  wire logic [WIDTH-1:0]   i_a,
  input  wire logic [WIDTH-1:0]   i_b,
  output logic                    o_done,
  output logic [2*WIDTH-1:0]      o_product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic                 r_busy;
  logic [CNT_W-1:0]     r_cnt;      // steps remaining after the current one
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;    // multiplicand, shifted left each step
  logic [WIDTH-1:0]     r_mplier;   // multiplier, shifted right each step
  logic [2*WIDTH-1:0]   w_addend;
  logic [2*WIDTH-1:0]   w_acc_next;

  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next = r_acc + w_addend;
  assign o_done     = r_busy && (r_cnt == '0);
  assign o_product  = w_acc_next;

  // Load on start, then one shift-add step per busy cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= CNT_W'(WIDTH - 1);
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt  <= r_cnt - CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu
//  Purpose  : Registered ALU with valid/ready handshake on both sides.
//             Single-cycle ops complete in the cycle after accept; MUL runs
//             on the serial multiplier for WIDTH cycles. Result and flags are
//             held until the consumer takes them.
//  Revision : 1.0  initial release
// ============================================================================
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  wire logic   clk,
  input  wire logic   rst,
  seq_alu_if.slave    bus
);

  logic [1:0]           r_state;
  logic [2*WIDTH-1:0]   r_result;
  logic [3:0]           r_flags;

  logic                 w_accept;
  logic                 w_is_mul;
  logic                 w_mul_done;
  logic [2*WIDTH-1:0]   w_product;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic                 w_lt;
  logic [WIDTH-1:0]     w_low;
  logic                 w_c;
  logic                 w_v;
  logic [3:0]           w_flags;
  logic [3:0]           w_mul_flags;

  assign w_accept = bus.in_valid && (r_state == S_IDLE);
  assign w_is_mul = (bus.op == OP_MUL);

  // Operands go straight into the multiplier registers on accept
  alu_mul_serial #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_accept && w_is_mul),
    .i_a       (bus.a),
    .i_b       (bus.b),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  // Arithmetic is done one bit wider so the carry/borrow falls out of the MSB
  assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_diff = {1'b0, bus.a} - {1'b0, bus.b};
  assign w_lt   = $signed(bus.a) < $signed(bus.b);

  // Single-cycle datapath: low-half result plus C/V for the current opcode
  always_comb begin
    w_low = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (bus.op)
      OP_AND: w_low = bus.a & bus.b;
      OP_OR:  w_low = bus.a | bus.b;
      OP_XOR: w_low = bus.a ^ bus.b;
      OP_ADD: begin
        w_low = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        w_low = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLT: w_low = {{(WIDTH-1){1'b0}}, w_lt};
      OP_NOT: w_low = ~bus.a;
      default: w_low = '0;
    endcase
  end

  // Pack flags for the single-cycle and multiply completion paths
  always_comb begin
    w_flags              = '0;
    w_flags[FLAG_Z]      = (w_low == '0);
    w_flags[FLAG_C]      = w_c;
    w_flags[FLAG_V]      = w_v;
    w_flags[FLAG_N]      = w_low[WIDTH-1];
    w_mul_flags          = '0;
    w_mul_flags[FLAG_Z]  = (w_product == '0);
    w_mul_flags[FLAG_N]  = w_product[2*WIDTH-1];
  end

  // Control FSM with result/flag capture; outputs hold while in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_state  <= S_BUSY;
            end else begin
              r_state  <= S_DONE;
              r_result <= {{WIDTH{1'b0}}, w_low};
              r_flags  <= w_flags;
            end
          end
        end
        S_BUSY: begin
          if (w_mul_done) begin
            r_state  <= S_DONE;
            r_result <= w_product;
            r_flags  <= w_mul_flags;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.flag_z    = r_flags[FLAG_Z];
  assign bus.flag_c    = r_flags[FLAG_C];
  assign bus.flag_v    = r_flags[FLAG_V];
  assign bus.flag_n    = r_flags[FLAG_N];

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_alu
//  Purpose  : Self-checking bench for seq_alu at WIDTH=4: directed vector
//             table, backpressure and reset-abort sequences, then random
//             operations against a plain-arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_alu;

  localparam int W = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] res;
    logic [3:0] fl;   // {z, c, v, n}
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: ordinary integer arithmetic on unsigned/signed values
  function automatic void model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                                output logic [7:0] res, output logic [3:0] fl);
    int ua, ub, sa, sb, r;
    logic z, c, v, n;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: r = ua & ub;
      3'd1: r = ua | ub;
      3'd2: r = ua ^ ub;
      3'd3: begin
        r = (ua + ub) % 16;
        c = (ua + ub) > 15;
        v = (sa + sb > 7) || (sa + sb < -8);
      end
      3'd4: begin
        r = (ua - ub + 16) % 16;
        c = ua < ub;
        v = (sa - sb > 7) || (sa - sb < -8);
      end
      3'd5: r = (sa < sb) ? 1 : 0;
      3'd6: r = ua * ub;
      default: r = 15 - ua;
    endcase
    z = (r == 0);
    n = (op == 3'd6) ? (r >= 128) : (r >= 8);
    res = 8'(r);
    fl  = {z, c, v, n};
  endfunction

  // One full transaction: offer, accept, wait for result, hold, consume
  task automatic run_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] er, input logic [3:0] ef,
                        input int hold, input bit pulse, input string tag);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op = 3'($urandom); bus.a = 4'($urandom); bus.b = 4'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.out_valid) check({tag, "_busy_ready"}, 32'(bus.in_ready), 32'd0);
    end while (!bus.out_valid && lat < 40);
    check({tag, "_latency"}, 32'(lat), (op == 3'd6) ? 32'd5 : 32'd1);
    check({tag, "_result"}, 32'(bus.result), 32'(er));
    check({tag, "_flags"}, 32'({bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n}), 32'(ef));
    check({tag, "_done_ready"}, 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        bus.in_valid = i[0];
        bus.op = 3'($urandom); bus.a = 4'($urandom); bus.b = 4'($urandom);
      end
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_hold_result"}, 32'(bus.result), 32'(er));
      check({tag, "_hold_flags"}, 32'({bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n}), 32'(ef));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_drop_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  vec_t vecs[11];

  initial begin
    logic [7:0] er;
    logic [3:0] ef;
    logic [2:0] rop;
    logic [3:0] ra, rb;
    bit         seen;
    total = 0;
    bad   = 0;

    //              op    a      b      res    {z,c,v,n}
    vecs[0]  = '{3'd3, 4'h7, 4'h9, 8'h00, 4'b1100};  // ADD wraps to zero
    vecs[1]  = '{3'd4, 4'h4, 4'h5, 8'h0F, 4'b0101};  // SUB borrow
    vecs[2]  = '{3'd3, 4'h7, 4'h1, 8'h08, 4'b0011};  // ADD overflow
    vecs[3]  = '{3'd6, 4'hF, 4'hF, 8'hE1, 4'b0001};  // MUL max
    vecs[4]  = '{3'd5, 4'h8, 4'h1, 8'h01, 4'b0000};  // SLT -8 < 1
    vecs[5]  = '{3'd0, 4'hC, 4'hA, 8'h08, 4'b0001};  // AND
    vecs[6]  = '{3'd1, 4'h0, 4'h0, 8'h00, 4'b1000};  // OR zero
    vecs[7]  = '{3'd7, 4'h5, 4'h3, 8'h0A, 4'b0001};  // NOT
    vecs[8]  = '{3'd6, 4'h0, 4'h9, 8'h00, 4'b1000};  // MUL zero
    vecs[9]  = '{3'd4, 4'h8, 4'h1, 8'h07, 4'b0010};  // SUB overflow -8-1
    vecs[10] = '{3'd5, 4'h1, 4'h8, 8'h00, 4'b1000};  // SLT 1 < -8 false

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op = 3'd0; bus.a = 4'd0; bus.b = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_result", 32'(bus.result), 32'd0);
    check("reset_flags", 32'({bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n}), 32'd0);

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].fl, 1, 1'b0,
             $sformatf("vec%0d", i));

    // Backpressure: XOR result held for 10 cycles while in_valid pulses
    run_op(3'd2, 4'hA, 4'h5, 8'h0F, 4'b0001, 10, 1'b1, "backpressure");
    run_op(3'd3, 4'h1, 4'h2, 8'h03, 4'b0000, 0, 1'b0, "after_bp");

    // Reset on the second BUSY cycle of a multiply aborts it
    @(negedge clk);
    bus.op = 3'd6; bus.a = 4'hF; bus.b = 4'hF; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("abort_busy1_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_result", 32'(bus.result), 32'd0);
    seen = 1'b0;
    repeat (10) begin
      if (bus.out_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_output", 32'(seen), 32'd0);
    run_op(3'd5, 4'h8, 4'h1, 8'h01, 4'b0000, 0, 1'b0, "slt_after_abort");

    // Random operations against the reference model
    for (int i = 0; i < 150; i++) begin
      rop = 3'($urandom);
      ra  = 4'($urandom);
      rb  = 4'($urandom);
      model(rop, ra, rb, er, ef);
      run_op(rop, ra, rb, er, ef, int'($urandom_range(0, 3)), 1'b0,
             $sformatf("rnd%0d_op%0d_%0h_%0h", i, rop, ra, rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
